// File: rtl/cmp_branch_ctl_pkg.sv
// ----------------------------------------------------------------------------
// cmp_branch_ctl_pkg
// Shared definitions for the compare-flag / branch-resolution block:
//   - bit positions of the {GT,EQ,LT} compare bus
//   - the two branch conditions that do not depend on flags
//   - FSM state encoding for the branch handshake
//   - one-hot legality helper for the compare bus
// Optional feature macro used by the top: CMP_BRANCH_FWD_EN.
// ----------------------------------------------------------------------------
package cmp_branch_ctl_pkg;

    localparam int FLAG_GT = 2;
    localparam int FLAG_EQ = 1;
    localparam int FLAG_LT = 0;

    localparam logic [2:0] COND_ALWAYS = 3'b111;
    localparam logic [2:0] COND_NEVER  = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    // A legal compare result has exactly one of GT/EQ/LT set.
    function automatic logic is_one_hot(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

endpackage

// File: rtl/cmp_branch_ctl_cond_eval.sv
// ----------------------------------------------------------------------------
// cmp_cond_eval
// Purely combinational branch-condition evaluation, shared with the decoder.
// Ports:
//   cond        in  [2:0]  taken-mask {GT,EQ,LT}; 111 = always, 000 = never
//   flags       in  [2:0]  compare flags to test the mask against
//   cmp         in  [2:0]  raw compare bus, checked for legality
//   taken       out        branch would be taken against 'flags'
//   needs_flags out        outcome depends on flags (cond not 000/111)
//   cmp_legal   out        'cmp' is one-hot
// ----------------------------------------------------------------------------
module cmp_cond_eval
    import cmp_branch_ctl_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    input  logic [2:0] cmp,
    output logic       taken,
    output logic       needs_flags,
    output logic       cmp_legal
);

    assign needs_flags = (cond != COND_ALWAYS) && (cond != COND_NEVER);

    assign taken = (cond == COND_ALWAYS)
                 | (cond[FLAG_GT] & flags[FLAG_GT])
                 | (cond[FLAG_EQ] & flags[FLAG_EQ])
                 | (cond[FLAG_LT] & flags[FLAG_LT]);

    assign cmp_legal = is_one_hot(cmp);

endmodule

// File: rtl/cmp_branch_ctl.sv
// ----------------------------------------------------------------------------
// cmp_branch_ctl
// Latches {GT,EQ,LT} compare flags on a CMP instruction, resolves conditional
// branches against them and owns the program counter.
// Optional feature: define CMP_BRANCH_FWD_EN to forward an incoming compare
// result straight into a coincident branch resolve instead of stalling.
// Ports:
//   clk         in           system clock, rising edge
//   rst         in           asynchronous active-high reset
//   cmp         in  [2:0]    compare result {GT,EQ,LT}
//   cmp_we      in           latch cmp into the flag register
//   pc_inc      in           advance PC by one
//   br_valid    in           branch request, held until br_ack
//   br_cond     in  [2:0]    taken-mask {GT,EQ,LT}
//   br_target   in  [PC_W]   branch destination
//   br_ack      out          one-cycle pulse: branch resolved
//   br_taken    out          outcome of the last resolve
//   pc          out [PC_W]   program counter
//   flags       out [2:0]    latched compare flags
//   flags_valid out          at least one cmp_we since reset
//   cmp_err     out          sticky: an illegal compare was latched
// ----------------------------------------------------------------------------
module cmp_branch_ctl
    import cmp_branch_ctl_pkg::*;
#(
    parameter int              PC_W   = 8,
    parameter logic [PC_W-1:0] PC_RST = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      cmp,
    input  logic            cmp_we,
    input  logic            pc_inc,
    input  logic            br_valid,
    input  logic [2:0]      br_cond,
    input  logic [PC_W-1:0] br_target,
    output logic            br_ack,
    output logic            br_taken,
    output logic [PC_W-1:0] pc,
    output logic [2:0]      flags,
    output logic            flags_valid,
    output logic            cmp_err
);

    state_t     state;
    state_t     state_next;
    logic       resolve;
    logic       can_resolve;
    logic       flags_ok;
    logic [2:0] flags_used;
    logic       taken;
    logic       needs_flags;
    logic       cmp_legal;

    cmp_cond_eval u_cond_eval (
        .cond        (br_cond),
        .flags       (flags_used),
        .cmp         (cmp),
        .taken       (taken),
        .needs_flags (needs_flags),
        .cmp_legal   (cmp_legal)
    );

`ifdef CMP_BRANCH_FWD_EN
    // A compare landing on the resolve edge is used directly; an illegal one
    // reads as no flags, matching what the flag register would hold.
    assign flags_used = cmp_we ? (cmp_legal ? cmp : 3'b000) : flags;
    assign flags_ok   = flags_valid | cmp_we;
`else
    // A compare landing on the resolve edge would make the register stale,
    // so hold off one cycle and use the freshly latched flags.
    assign flags_used = flags;
    assign flags_ok   = flags_valid & ~cmp_we;
`endif

    assign can_resolve = ~needs_flags | flags_ok;

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    always_comb begin
        state_next = state;
        resolve    = 1'b0;
        case (state)
            IDLE: begin
                if (br_valid) begin
                    if (can_resolve) begin
                        resolve    = 1'b1;
                        state_next = ACK;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                // Request withdrawn: abandon it without touching the PC.
                if (!br_valid) begin
                    state_next = IDLE;
                end else if (can_resolve) begin
                    resolve    = 1'b1;
                    state_next = ACK;
                end
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments and an asynchronous reset, so
    // every register samples pre-edge values and clears without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Decoding the ack from the state register makes it fall the instant
    // reset is asserted mid-handshake.
    assign br_ack = (state == ACK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags       <= 3'b000;
            flags_valid <= 1'b0;
            cmp_err     <= 1'b0;
        end else if (cmp_we) begin
            flags       <= cmp_legal ? cmp : 3'b000;
            flags_valid <= 1'b1;
            if (!cmp_legal) begin
                cmp_err <= 1'b1;
            end
        end
    end

    // A taken branch wins over pc_inc; a not-taken resolve lets it through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= PC_RST;
            br_taken <= 1'b0;
        end else begin
            if (resolve) begin
                br_taken <= taken;
            end
            if (resolve && taken) begin
                pc <= br_target;
            end else if (pc_inc) begin
                pc <= pc + PC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cmp_branch_ctl.sv
// ----------------------------------------------------------------------------
// tb_cmp_branch_ctl
// Self-checking bench for cmp_branch_ctl: reset values, a table of branch
// vectors, then hand-written sequences for stalls, forwarding, illegal
// compares, withdrawn requests and reset during the ack cycle.
// ----------------------------------------------------------------------------
module tb_cmp_branch_ctl;

`ifdef CMP_BRANCH_FWD_EN
    localparam int COINCIDE_LAT = 1;
`else
    localparam int COINCIDE_LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] cmp = 3'b000;
    logic       cmp_we = 1'b0;
    logic       pc_inc = 1'b0;
    logic       br_valid = 1'b0;
    logic [2:0] br_cond = 3'b000;
    logic [7:0] br_target = 8'h00;
    logic       br_ack;
    logic       br_taken;
    logic [7:0] pc;
    logic [2:0] flags;
    logic       flags_valid;
    logic       cmp_err;

    cmp_branch_ctl #(.PC_W(8), .PC_RST(8'h00)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmp         (cmp),
        .cmp_we      (cmp_we),
        .pc_inc      (pc_inc),
        .br_valid    (br_valid),
        .br_cond     (br_cond),
        .br_target   (br_target),
        .br_ack      (br_ack),
        .br_taken    (br_taken),
        .pc          (pc),
        .flags       (flags),
        .flags_valid (flags_valid),
        .cmp_err     (cmp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       do_cmp;
        logic [2:0] c;
        logic [2:0] cond;
        logic [7:0] target;
        logic       inc;
        logic       exp_taken;
        logic [7:0] exp_pc;
    } vec_t;

    typedef struct {
        logic       taken;
        logic [7:0] pc;
        int         lat;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmp_we = 1'b0; pc_inc = 1'b0; br_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic latch_cmp(input logic [2:0] c);
        cmp = c;
        cmp_we = 1'b1;
        tick();
        cmp_we = 1'b0;
    endtask

    // Drive a branch request and record what the DUT must eventually report.
    task automatic issue(input logic [2:0] cond, input logic [7:0] target, input logic inc,
                         input logic exp_taken, input logic [7:0] exp_pc, input int exp_lat);
        exp_t e;
        e.taken = exp_taken; e.pc = exp_pc; e.lat = exp_lat;
        sb.push_back(e);
        br_valid  = 1'b1;
        br_cond   = cond;
        br_target = target;
        pc_inc    = inc;
    endtask

    // Wait (bounded) for the ack; cmp_we and pc_inc are single-edge pulses.
    task automatic collect(input int budget);
        int   lat;
        exp_t e;
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            cmp_we = 1'b0;
            pc_inc = 1'b0;
            if (br_ack) begin
                lat = i;
                break;
            end
        end
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("ack_latency", lat, e.lat);
            check("br_taken", {31'd0, br_taken}, {31'd0, e.taken});
            check("pc_after_branch", {24'd0, pc}, {24'd0, e.pc});
        end
    endtask

    task automatic finish_branch();
        br_valid = 1'b0;
        tick();
        check("ack_one_cycle", {31'd0, br_ack}, 32'd0);
    endtask

    initial begin
        int ack_seen;

        vecs[0] = '{1'b0, 3'b000, 3'b111, 8'h05, 1'b0, 1'b1, 8'h05};
        vecs[1] = '{1'b1, 3'b100, 3'b001, 8'h20, 1'b1, 1'b0, 8'h06};
        vecs[2] = '{1'b0, 3'b000, 3'b100, 8'h30, 1'b1, 1'b1, 8'h30};
        vecs[3] = '{1'b0, 3'b000, 3'b011, 8'h50, 1'b0, 1'b0, 8'h30};
        vecs[4] = '{1'b1, 3'b010, 3'b010, 8'h60, 1'b0, 1'b1, 8'h60};
        vecs[5] = '{1'b0, 3'b000, 3'b000, 8'h70, 1'b1, 1'b0, 8'h61};
        vecs[6] = '{1'b1, 3'b001, 3'b101, 8'h80, 1'b0, 1'b1, 8'h80};
        vecs[7] = '{1'b0, 3'b000, 3'b110, 8'h90, 1'b1, 1'b0, 8'h81};
        vecs[8] = '{1'b0, 3'b000, 3'b111, 8'hFF, 1'b1, 1'b1, 8'hFF};

        // Reset values.
        do_reset();
        check("rst_pc", {24'd0, pc}, 32'h00);
        check("rst_flags", {29'd0, flags}, 32'd0);
        check("rst_flags_valid", {31'd0, flags_valid}, 32'd0);
        check("rst_cmp_err", {31'd0, cmp_err}, 32'd0);
        check("rst_br_ack", {31'd0, br_ack}, 32'd0);
        check("rst_br_taken", {31'd0, br_taken}, 32'd0);

        // Three increments, then an unconditional branch.
        pc_inc = 1'b1;
        tick(); tick(); tick();
        pc_inc = 1'b0;
        check("pc_inc3", {24'd0, pc}, 32'h03);
        issue(3'b111, 8'h40, 1'b0, 1'b1, 8'h40, 1);
        collect(8);
        finish_branch();

        // Table of branches with flags already settled.
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].do_cmp) begin
                latch_cmp(vecs[i].c);
                check("vec_flags", {29'd0, flags}, {29'd0, vecs[i].c});
            end
            issue(vecs[i].cond, vecs[i].target, vecs[i].inc,
                  vecs[i].exp_taken, vecs[i].exp_pc, 1);
            collect(8);
            finish_branch();
        end

        // Increment wraps from FF.
        pc_inc = 1'b1;
        tick();
        pc_inc = 1'b0;
        check("pc_wrap", {24'd0, pc}, 32'h00);

        // Branch needing flags right after reset waits until a compare lands.
        do_reset();
        issue(3'b010, 8'h44, 1'b0, 1'b1, 8'h44, COINCIDE_LAT);
        ack_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (br_ack) ack_seen++;
        end
        check("wait_no_ack", ack_seen, 0);
        check("wait_pc_hold", {24'd0, pc}, 32'h00);
        cmp = 3'b010;
        cmp_we = 1'b1;
        collect(8);
        finish_branch();
        check("wait_flags", {29'd0, flags}, 32'b010);
        check("wait_flags_valid", {31'd0, flags_valid}, 32'd1);

        // Compare and branch request on the same edge.
        cmp = 3'b001;
        cmp_we = 1'b1;
        issue(3'b001, 8'h22, 1'b0, 1'b1, 8'h22, COINCIDE_LAT);
        collect(8);
        finish_branch();

        // Illegal compare clears the flags and sets the sticky error.
        latch_cmp(3'b011);
        check("illegal_err", {31'd0, cmp_err}, 32'd1);
        check("illegal_flags", {29'd0, flags}, 32'd0);
        issue(3'b110, 8'h33, 1'b0, 1'b0, 8'h22, 1);
        collect(8);
        finish_branch();
        latch_cmp(3'b100);
        check("err_sticky", {31'd0, cmp_err}, 32'd1);
        check("legal_after_err", {29'd0, flags}, 32'b100);
        do_reset();
        check("err_cleared", {31'd0, cmp_err}, 32'd0);

        // Request withdrawn while waiting: no ack, no PC change.
        ack_seen = 0;
        br_valid = 1'b1; br_cond = 3'b100; br_target = 8'h77;
        tick(); if (br_ack) ack_seen++;
        tick(); if (br_ack) ack_seen++;
        br_valid = 1'b0;
        tick(); if (br_ack) ack_seen++;
        latch_cmp(3'b100); if (br_ack) ack_seen++;
        tick(); if (br_ack) ack_seen++;
        check("drop_no_ack", ack_seen, 0);
        check("drop_pc_hold", {24'd0, pc}, 32'h00);

        // Reset asserted during the ack cycle.
        issue(3'b111, 8'h55, 1'b0, 1'b1, 8'h55, 1);
        collect(8);
        #2 rst = 1'b1;
        #1;
        check("rst_in_ack_br_ack", {31'd0, br_ack}, 32'd0);
        check("rst_in_ack_pc", {24'd0, pc}, 32'h00);
        br_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_idle", {31'd0, br_ack}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
